keypad_scan_4x4: RTL
====================

Name: keypad_scan_4x4

Overview:
Input-side counterpart of the counter's multiplexed 7-segment display scanner. It drives the rows of a 4x4 matrix keypad one at a time, samples the columns, and debounces the result. Each debounced key press produces a 4-bit hex key code and a one-cycle valid strobe. These replace the raw manual count pulse and front-panel switches as operator input to the counter/display blocks.

Parameters:
ROW_CYCLES, 100, clock cycles each row stays driven (1 ms at 100 kHz); legal range >=4.
DEBOUNCE_SCANS, 5, consecutive identical full scans needed to accept a press or a release; legal range >=1.

Ports:
clk100khz  input  1  system clock; all logic on its rising edge.
rst  input  1  asynchronous active-low reset.
col  input  4  keypad columns; active-low, pulled up externally; asynchronous to clk100khz.
row  output  4  keypad row drive; active-low, exactly one bit low at a time.
key_code  output  4  hex code of the last accepted key, {row_idx[1:0], col_idx[1:0]}.
key_valid  output  1  one-cycle pulse when a debounced press is accepted.
key_held  output  1  high from press acceptance until release acceptance.
multi_key  output  1  high while the last completed scan saw two or more keys.

Behaviour:
- Reset (rst low, acts immediately with no clock):
  - row=4'b1110, row_idx=0, divider=0.
  - col synchronizer=4'b1111, snapshot=16'h0000.
  - FSM=IDLE, debounce count=0.
  - key_code=0, key_valid=0, key_held=0, multi_key=0.
- col passes through a 2-flop synchronizer, reset value all ones.
- Divider counts 0..ROW_CYCLES-1 and wraps to 0.
- When divider==ROW_CYCLES-1:
  - snapshot[row_idx*4+c] <= ~col_sync[c].
  - On the next edge, row_idx increments mod 4 and row rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- Full scan period = 4*ROW_CYCLES cycles.
- scan_done: registered strobe, high for the one cycle after the row-3 sample.
- Scan classification at scan_done: NONE (0 bits set), SINGLE (exactly 1 bit set, code = its bit index), MULTI (>=2 bits set).
- multi_key is updated at every scan_done to (class==MULTI).
- The FSM evaluates only on edges where scan_done=1:
  - IDLE:
    - SINGLE -> PRESS_CHK, cand=code, cnt=1.
    - Otherwise stay in IDLE.
  - PRESS_CHK:
    - SINGLE with the same cand: cnt+1. When cnt+1==DEBOUNCE_SCANS: key_code<=cand, key_valid=1 next cycle only, key_held<=1, go to HELD.
    - SINGLE with a different code: restart with cand=new code, cnt=1.
    - NONE or MULTI -> IDLE, cnt=0.
  - HELD:
    - NONE -> REL_CHK, cnt=1; when DEBOUNCE_SCANS==1, go directly to IDLE with key_held<=0.
    - Otherwise stay in HELD. Rolling to another key or adding keys never produces a new strobe.
  - REL_CHK:
    - NONE: cnt+1. When cnt+1==DEBOUNCE_SCANS: key_held<=0, go to IDLE.
    - Any key -> HELD, with no new key_valid.
- DEBOUNCE_SCANS==1: a press is accepted on the first SINGLE scan directly from IDLE.
- key_valid is never high for two consecutive cycles. At most one pulse per press/release cycle.
- key_code holds its value until the next accepted press.
- Latency:
  - From the first stable scan's row-3 sample to key_valid: (DEBOUNCE_SCANS-1)*4*ROW_CYCLES + 2 cycles.
  - Column synchronizer delay adds up to 2 cycles before sampling.
- Counter widths are $clog2 of their ranges. The divider and cnt never overflow.
- Reset mid-operation: all state is cleared immediately. After release, scanning restarts at row 0 with divider 0.

Test Plan:
(All with ROW_CYCLES=4, DEBOUNCE_SCANS=3; 1 scan = 16 cycles. Keypad model: col[c] is low while row[r] is low and key (r,c) is pressed.)
- Reset: hold rst low mid-scan -> row=1110, key_code=0, key_valid=0, key_held=0, multi_key=0 while low; row then rotates 1110/1101/1011/0111 every 4 cycles.
- Clean press: hold key (1,2) for 6 scans -> exactly one key_valid pulse, key_code=4'h6, key_held=1 rising with the pulse, 34 cycles after the first stable row-3 sample.
- Bounce: press (3,3) for 2 scans, release 1 scan, press 2 scans, release -> no key_valid, key_held stays 0.
- Release debounce: after (0,1) is accepted (key_code=4'h1), release 1 scan then re-press -> key_held stays 1 and no new pulse; a full release of 3 scans -> key_held=0.
- Multi-key: press (0,0) and (2,3) together for 5 scans -> multi_key=1 after the first scan, no key_valid; release (0,0) -> multi_key=0 and (2,3) is accepted, key_code=4'hB, after 3 more scans.
- Reset while HELD: assert rst -> key_held=0 immediately; release rst with the key still pressed -> fresh acceptance with one new key_valid after 3 scans.

Source files
------------

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner: rotates an active-low row drive, samples the
// synchronised columns once per row, and debounces whole scans into key events.
module keypad_scan_4x4 #(
  parameter int ROW_CYCLES     = 100,
  parameter int DEBOUNCE_SCANS = 5
) (
  input  logic       clk100khz,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);

  localparam int DIV_W = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ROW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

  logic [3:0]       col_meta_q, col_sync_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       row_q, row_d;
  logic             adv_q, adv_d;
  logic             scan_done_q, scan_done_d;
  logic [15:0]      snap_q, snap_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             multi_q, multi_d;

  logic [1:0]       n_set;
  logic [3:0]       hit_idx;
  logic             is_none, is_single, is_multi;

  // Row advances one cycle after its sample, so the sample always sees a settled row.
  always_comb begin
    div_d       = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    adv_d       = (div_q == DIV_LAST);
    scan_done_d = adv_d && (row_idx_q == 2'd3);
    snap_d      = snap_q;
    if (adv_d) begin
      for (int unsigned c = 0; c < 4; c++) begin
        snap_d[{row_idx_q, 2'(c)}] = ~col_sync_q[c];
      end
    end
    row_idx_d = adv_q ? row_idx_q + 2'd1 : row_idx_q;
    row_d     = adv_q ? {row_q[2:0], row_q[3]} : row_q;
  end

  // Saturating popcount (0, 1, 2+) plus index of a set bit.
  always_comb begin
    n_set   = 2'd0;
    hit_idx = 4'd0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (snap_q[i]) begin
        hit_idx = 4'(i);
        if (n_set != 2'd2) n_set = n_set + 2'd1;
      end
    end
    is_none   = (n_set == 2'd0);
    is_single = (n_set == 2'd1);
    is_multi  = (n_set == 2'd2);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    multi_d     = multi_q;
    if (scan_done_q) begin
      multi_d = is_multi;
      unique case (state_q)
        IDLE: begin
          if (is_single) begin
            if (DEBOUNCE_SCANS == 1) begin
              key_code_d  = hit_idx;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              state_d     = HELD;
            end else begin
              cand_d  = hit_idx;
              cnt_d   = CNT_ONE;
              state_d = PRESS_CHK;
            end
          end
        end
        PRESS_CHK: begin
          if (is_single && hit_idx == cand_q) begin
            if (cnt_q == CNT_LAST) begin
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = '0;
              state_d     = HELD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (is_single) begin
            cand_d = hit_idx;
            cnt_d  = CNT_ONE;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        HELD: begin
          if (is_none) begin
            if (DEBOUNCE_SCANS == 1) begin
              key_held_d = 1'b0;
              state_d    = IDLE;
            end else begin
              cnt_d   = CNT_ONE;
              state_d = REL_CHK;
            end
          end
        end
        REL_CHK: begin
          if (is_none) begin
            if (cnt_q == CNT_LAST) begin
              key_held_d = 1'b0;
              cnt_d      = '0;
              state_d    = IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d   = '0;
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk100khz or negedge rst) begin
    if (!rst) begin
      col_meta_q  <= '1;
      col_sync_q  <= '1;
      div_q       <= '0;
      row_idx_q   <= '0;
      row_q       <= 4'b1110;
      adv_q       <= 1'b0;
      scan_done_q <= 1'b0;
      snap_q      <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      col_meta_q  <= col;
      col_sync_q  <= col_meta_q;
      div_q       <= div_d;
      row_idx_q   <= row_idx_d;
      row_q       <= row_d;
      adv_q       <= adv_d;
      scan_done_q <= scan_done_d;
      snap_q      <= snap_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_q     <= multi_d;
    end
  end

  assign row       = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_key = multi_q;

endmodule
